// File: rtl/fifo_rd_stream.sv
// Read-side stream controller for the async FIFO: pops into a 2-entry buffer, valid/ready out, drain/flush handshake.
// Optional word counter port word_cnt is built only when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  drain_req,
  output logic                  drain_done
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_e;

  state_e                state_q;
  logic                  drain_done_q;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  rinc_raw;
  logic                  push;
  logic                  pop;
  logic                  flush_start;

  assign out_valid   = (cnt_q != 2'd0);
  assign out_data    = head_q;
  assign drain_done  = drain_done_q;
  assign pop         = out_valid & out_ready;
  assign flush_start = (state_q == ST_RUN) & drain_req;

  // Pop decision uses only registered count, so out_ready never reaches rinc.
  always_comb begin
    rinc_raw = 1'b0;
    case (state_q)
      ST_RUN:   rinc_raw = enable & ~rempty & (cnt_q != 2'd2);
      ST_FLUSH: rinc_raw = ~rempty;
      default:  rinc_raw = 1'b0;
    endcase
  end

  assign rinc = rinc_raw & rrst_n;
  assign push = rinc & (state_q == ST_RUN);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_start) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = rdata;
          else               tail_d = rdata;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // New word queues behind whatever becomes the head.
          if (cnt_q == 2'd1) begin
            head_d = rdata;
          end else begin
            head_d = tail_q;
            tail_d = rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (drain_req) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (rempty) begin
            state_q      <= ST_DONE;
            drain_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain_req) begin
            state_q      <= ST_RUN;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)          word_cnt_q <= '0;
    else if (flush_start) word_cnt_q <= '0;
    else if (pop)         word_cnt_q <= word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-backed FIFO environment plus a queue-level model of delivered words.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic          enable = 1'b0;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          rinc;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          drain_req = 1'b0;
  logic          drain_done;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CW-1:0] word_cnt;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .enable     (enable),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .drain_req  (drain_req),
    .drain_done (drain_done)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Environment FIFO contents and the model: mq holds words taken from the FIFO but not yet delivered.
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] mq[$];
  int            mode = 0;   // 0 normal streaming, 1 flushing, 2 drain acknowledged
  int unsigned   exp_wc = 0;
  int            deliv = 0;
  int            rinc_seen = 0;
  int            p_en = 100, p_ready = 100, p_tog = 0, p_fill = 0;

  bit            s_rst, s_rdy, s_drq, s_empty, s_rinc, e_rinc, e_valid;
  logic [DW-1:0] s_rdata;

  task automatic env_update();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? DW'($urandom) : fifo[0];
  endtask

  task automatic drive();
    enable    = ($urandom_range(99) < p_en);
    out_ready = ($urandom_range(99) < p_ready);
    if ($urandom_range(99) < p_tog) drain_req = ~drain_req;
    if ($urandom_range(99) < p_fill && fifo.size() < 16) fifo.push_back(DW'($urandom));
    env_update();
  endtask

  task automatic sample_and_check();
    #2;
    e_rinc  = rrst_n && ((mode == 0 && enable && fifo.size() > 0 && mq.size() < 2) ||
                         (mode == 1 && fifo.size() > 0));
    e_valid = (mq.size() != 0);
    check("rinc", rinc, e_rinc);
    check("out_valid", out_valid, e_valid);
    if (e_valid) check("out_data", out_data, mq[0]);
    check("drain_done", drain_done, mode == 2);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("word_cnt", word_cnt, CW'(exp_wc));
`endif
    s_rst   = rrst_n;
    s_rdy   = out_ready;
    s_drq   = drain_req;
    s_empty = rempty;
    s_rdata = rdata;
    s_rinc  = rinc;
  endtask

  task automatic advance();
    @(posedge rclk);
    #1;
    if (s_rinc && fifo.size() > 0) begin
      void'(fifo.pop_front());
      rinc_seen++;
    end
    if (s_rst) begin
      case (mode)
        0: begin
          if (s_drq) begin
            mq.delete();
            exp_wc = 0;
            mode = 1;
          end else begin
            if (e_valid && s_rdy) begin
              void'(mq.pop_front());
              exp_wc++;
              deliv++;
            end
            if (e_rinc) mq.push_back(s_rdata);
          end
        end
        1: if (s_empty) mode = 2;
        default: if (!s_drq) mode = 0;
      endcase
    end
  endtask

  task automatic cycle();
    drive();
    sample_and_check();
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    mq.delete();
    mode = 0;
    exp_wc = 0;
    #2;
    check("rst_rinc", rinc, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_done", drain_done, 1'b0);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
  endtask

  int base;

  initial begin
    for (int i = 0; i < 8; i++) fifo.push_back(DW'(8'h11 + i));
    enable = 1'b1;
    out_ready = 1'b1;
    env_update();
    #1;
    check("rst_rinc", rinc, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_done", drain_done, 1'b0);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // Streaming of the preloaded words at full rate.
    p_en = 100; p_ready = 100; p_tog = 0; p_fill = 0;
    rinc_seen = 0;
    run(12);
    check("stream_deliv", deliv, 8);
    check("stream_rinc", rinc_seen, 8);

    // Backpressure: only two words may be taken while the sink stalls.
    for (int i = 0; i < 4; i++) fifo.push_back(DW'(8'hA0 + i));
    p_ready = 0;
    rinc_seen = 0;
    run(6);
    check("bp_rinc", rinc_seen, 2);
    base = deliv;
    p_ready = 100;
    run(8);
    check("bp_deliv", deliv - base, 4);

    // Drain with two words buffered and five left in the FIFO.
    p_ready = 0;
    for (int i = 0; i < 7; i++) fifo.push_back(DW'(8'hC0 + i));
    run(3);
    rinc_seen = 0;
    drain_req = 1'b1;
    cycle();
    drain_req = 1'b0;
    run(10);
    check("drain_rinc", rinc_seen, 5);
    check("drain_mode", mode, 0);

    // Randomized mixes of enable, backpressure, drain requests and FIFO occupancy.
    p_en = 100; p_ready = 100; p_tog = 0; p_fill = 50;  run(600);
    p_en = 70;  p_ready = 50;  p_tog = 3; p_fill = 60;  run(600);
    p_en = 50;  p_ready = 30;  p_tog = 5; p_fill = 80;  run(600);
    p_en = 90;  p_ready = 80;  p_tog = 2; p_fill = 20;  run(600);
    p_en = 0;   p_ready = 100; p_tog = 0; p_fill = 40;  run(50);
    do_reset();
    p_en = 80;  p_ready = 60;  p_tog = 2; p_fill = 50;  run(400);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Consumer-side controller for the async FIFO read port, living in the rclk domain.
- Issues rinc pops against rempty and captures rdata into a 2-entry output buffer.
- Presents captured words as a valid/ready stream to downstream logic.
- Provides a drain sequence that flushes the buffer and discards all FIFO contents until the FIFO is empty, then acknowledges.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of the output stream
- CNT_WIDTH, 16, width of the optional word counter

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  asynchronous active-low reset
- enable  input  1  allows pops in RUN state; low = hold FIFO, keep draining buffer
- rempty  input  1  FIFO empty flag, rclk domain
- rdata  input  DATA_WIDTH  FIFO word at current read address; combinational, valid whenever rempty=0
- rinc  output  1  pop strobe to FIFO read pointer logic
- out_valid  output  1  output word available
- out_data  output  DATA_WIDTH  head-of-buffer word
- out_ready  input  1  downstream accepts out_data this cycle
- drain_req  input  1  level request to flush buffer and discard FIFO contents
- drain_done  output  1  drain complete, held until drain_req drops
- word_cnt  output  CNT_WIDTH  words delivered downstream (only with FIFO_RD_STREAM_CNT_EN)

Behaviour:
- Reset (rrst_n=0, async): state=RUN, buffer count=0, out_valid=0, out_data=0, drain_done=0, word_cnt=0. rinc=0 while in reset.
- Reset released mid-operation: buffer contents are lost. FIFO contents are untouched by this block.
- Buffer: 2-entry FIFO of registers, count in 0..2.
  - out_valid = (count!=0).
  - out_data = head entry, driven from a register.
  - out_data holds stable while out_valid=1 and out_ready=0.
- State RUN:
  - rinc = enable & ~rempty & (count<2). rinc is combinational from registered count and the rempty/enable inputs.
  - Push occurs when rinc=1: rdata is written into the buffer on the same rclk edge.
  - Pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged, with the new word queued behind the head. This sustains 1 word/cycle with count=1.
  - count=2 blocks rinc until a pop has registered. There is no combinational out_ready→rinc path.
  - count=0 with push: out_valid=1 on the next cycle. Minimum FIFO-to-output latency is 1 cycle.
- RUN→FLUSH: drain_req=1 sampled at a rising edge. On that edge:
  - count forces to 0 and any same-cycle push is discarded.
  - out_valid=0 from the next cycle.
- State FLUSH:
  - rinc = ~rempty, independent of enable and count. Popped words are discarded.
  - out_valid=0 and out_ready is ignored.
  - rempty=1 sampled at a rising edge → DONE.
  - If drain_req drops during FLUSH, flushing continues until rempty=1, then goes to DONE.
- State DONE:
  - drain_done=1 (registered), rinc=0, out_valid=0.
  - drain_req=0 sampled → RUN, with drain_done=0 on the next cycle.
- drain_done is low in RUN and FLUSH.
- Wrap-around: the block keeps no pointers, so FIFO pointer wrap is invisible to it. word_cnt wraps modulo 2^CNT_WIDTH.
- Simultaneous rempty rising with rinc: rinc is combinational on rempty, so no pop is issued on an empty FIFO.

Optional Feature:
- Macro: FIFO_RD_STREAM_CNT_EN.
- Defined: word_cnt port exists.
  - Increments by 1 on every accepted output word (out_valid & out_ready).
  - Reset to 0 by rrst_n and on entry to FLUSH.
  - Not incremented for discarded words.
- Undefined: no word_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset: hold rrst_n=0 with rempty=0 → rinc=0, out_valid=0, out_data=0, drain_done=0. Release → first rinc=1 in the same cycle as release when enable=1.
- Streaming: FIFO preloaded 0x11..0x18, out_ready=1 constantly → rinc high 8 consecutive cycles, out_data 0x11..0x18 one per cycle starting 1 cycle after first rinc, word_cnt=8.
- Backpressure: 4 words queued, out_ready=0 → exactly 2 rinc pulses, out_data=first word held stable. Raise out_ready → remaining words delivered in order, none lost or duplicated.
- Drain: 2 words buffered, 5 in FIFO, pulse drain_req → out_valid=0 next cycle, 5 rinc pulses, then drain_done=1. Drop drain_req → drain_done=0, state RUN, word_cnt=0.
- enable=0 with rempty=0 and count=1, out_ready=1 → buffered word delivered, then out_valid=0 and rinc stays 0 until enable=1.
- Empty edge: rempty toggles 1→0→1 for single cycles → exactly one rinc per low cycle, no pop while rempty=1.
